spi_slave_rx: RTL and testbench

//  SPI slave front end: the far end of the divided serial clock made by the master-side divider.

---
 rtl/spi_slave_rx.sv | 188 ++++++++++++++++++
 tb/tb_spi_slave_rx.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_rx.sv
// SPI slave: oversampled SCK/CS_N/MOSI, MSB-first deserialiser with RX/TX valid/ready handshakes.
// SPI_SLAVE_RX_FRAME_ERR_EN adds o_frame_err for frames ended mid-word.
module spi_slave_rx #(
  parameter int DATA_W      = 8,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_sck,
  input  logic              i_cs_n,
  input  logic              i_mosi,
  output logic              o_miso,
  output logic              o_miso_oe,
  output logic [DATA_W-1:0] o_rx_data,
  output logic              o_rx_valid,
  input  logic              i_rx_ready,
  input  logic [DATA_W-1:0] i_tx_data,
  input  logic              i_tx_valid,
  output logic              o_tx_ready,
  output logic              o_overrun,
  output logic              o_underrun
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
  ,
  output logic              o_frame_err
`endif
);

  localparam int CW          = $clog2(DATA_W);
  localparam bit SAMPLE_RISE = (CPOL == CPHA);

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t state, state_nxt;

  logic [SYNC_STAGES-1:0] sck_sync, cs_sync, mosi_sync;
  logic                   sck_prev, cs_prev;
  logic [SYNC_STAGES:0]   flush;

  logic              sck_now, cs_now, mosi_now;
  logic              sample_edge, shift_edge, cs_fall, cs_rise;
  logic              start, stop, do_sample, do_shift_edge, do_shift, do_load, last_bit;

  logic [CW-1:0]     bit_cnt;
  logic              started;
  logic              word_done;
  logic [DATA_W-1:0] rx_shift, tx_shift, hold_reg;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sck_sync  <= {SYNC_STAGES{CPOL}};
      cs_sync   <= '1;
      mosi_sync <= '0;
      sck_prev  <= CPOL;
      cs_prev   <= 1'b1;
      flush     <= '0;
    end else begin
      sck_sync  <= {sck_sync[SYNC_STAGES-2:0], i_sck};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], i_cs_n};
      mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], i_mosi};
      sck_prev  <= sck_sync[SYNC_STAGES-1];
      cs_prev   <= cs_sync[SYNC_STAGES-1];
      flush     <= {flush[SYNC_STAGES-1:0], 1'b1};
    end
  end

  assign sck_now  = sck_sync[SYNC_STAGES-1];
  assign cs_now   = cs_sync[SYNC_STAGES-1];
  assign mosi_now = mosi_sync[SYNC_STAGES-1];

  // cs_prev only holds a real pad sample once the pipeline has refilled after reset,
  // so a CS_N held low across reset cannot fake a frame start.
  assign cs_fall     = flush[SYNC_STAGES] & cs_prev & ~cs_now;
  assign cs_rise     = ~cs_prev & cs_now;
  assign sample_edge = SAMPLE_RISE ? (sck_now & ~sck_prev) : (~sck_now & sck_prev);
  assign shift_edge  = SAMPLE_RISE ? (~sck_now & sck_prev) : (sck_now & ~sck_prev);

  always_ff @(posedge i_clk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    start         = 1'b0;
    stop          = 1'b0;
    do_sample     = 1'b0;
    do_shift_edge = 1'b0;
    do_shift      = 1'b0;
    do_load       = 1'b0;
    last_bit      = (bit_cnt == CW'(DATA_W - 1));
    case (state)
      IDLE: begin
        if (cs_fall) begin
          state_nxt = ACTIVE;
          start     = 1'b1;
          do_load   = 1'b1;
        end
      end
      ACTIVE: begin
        if (cs_rise) begin
          state_nxt = IDLE;
          stop      = 1'b1;
        end else begin
          do_sample     = sample_edge;
          do_shift_edge = shift_edge;
          // bit_cnt==0 on a shift edge: either the CPHA=1 opening edge or a word boundary
          do_shift      = shift_edge & (bit_cnt != '0);
          do_load       = shift_edge & (bit_cnt == '0) & started;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      bit_cnt    <= '0;
      started    <= 1'b0;
      word_done  <= 1'b0;
      rx_shift   <= '0;
      tx_shift   <= '0;
      hold_reg   <= '0;
      o_miso_oe  <= 1'b0;
      o_rx_data  <= '0;
      o_rx_valid <= 1'b0;
      o_tx_ready <= 1'b1;
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
    end else begin
      o_overrun  <= 1'b0;
      o_underrun <= 1'b0;
      word_done  <= 1'b0;

      if (start) begin
        bit_cnt   <= '0;
        started   <= 1'b0;
        o_miso_oe <= 1'b1;
      end
      if (stop) begin
        bit_cnt   <= '0;
        started   <= 1'b0;
        o_miso_oe <= 1'b0;
        tx_shift  <= '0;
      end
      if (do_sample) begin
        rx_shift  <= {rx_shift[DATA_W-2:0], mosi_now};
        bit_cnt   <= last_bit ? '0 : bit_cnt + CW'(1);
        word_done <= last_bit;
      end
      if (do_shift_edge) started <= 1'b1;
      if (do_shift)      tx_shift <= {tx_shift[DATA_W-2:0], 1'b0};

      if (do_load) begin
        tx_shift   <= o_tx_ready ? '1 : hold_reg;
        o_underrun <= o_tx_ready;
        o_tx_ready <= 1'b1;
      end
      // A write in the load cycle is not bypassed into the shifter; it fills the holding reg.
      if (i_tx_valid && o_tx_ready) begin
        hold_reg   <= i_tx_data;
        o_tx_ready <= 1'b0;
      end

      if (word_done) begin
        if (!o_rx_valid || i_rx_ready) begin
          o_rx_data  <= rx_shift;
          o_rx_valid <= 1'b1;
        end else begin
          o_overrun  <= 1'b1;
        end
      end else if (o_rx_valid && i_rx_ready) begin
        o_rx_valid <= 1'b0;
      end
    end
  end

  assign o_miso = o_miso_oe & tx_shift[DATA_W-1];

`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst) o_frame_err <= 1'b0;
    else       o_frame_err <= stop & (bit_cnt != '0);
  end
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench for spi_slave_rx: one instance per SPI mode, index m = {CPOL,CPHA}.
`timescale 1ns/1ps
module tb_spi_slave_rx;

  localparam int HALF = 60;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] sck = 4'b1100;
  logic [3:0] cs_n = 4'hF;
  logic [3:0] mosi = 4'h0;
  logic [3:0] rx_ready = 4'h0;
  logic [3:0] tx_valid = 4'h0;
  logic [3:0] miso, miso_oe, rx_valid, tx_ready, overrun, underrun;
  logic [7:0] rx_data [4];
  logic [7:0] tx_data [4];
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
  logic [3:0] frame_err;
  int         ferr_cnt [4];
`endif

  int ovr_cnt [4];
  int und_cnt [4];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam bit POL = bit'(g / 2);
    localparam bit PHA = bit'(g % 2);
    spi_slave_rx #(.DATA_W(8), .CPOL(POL), .CPHA(PHA), .SYNC_STAGES(2)) dut (
      .i_clk      (clk),
      .i_rst      (rst),
      .i_sck      (sck[g]),
      .i_cs_n     (cs_n[g]),
      .i_mosi     (mosi[g]),
      .o_miso     (miso[g]),
      .o_miso_oe  (miso_oe[g]),
      .o_rx_data  (rx_data[g]),
      .o_rx_valid (rx_valid[g]),
      .i_rx_ready (rx_ready[g]),
      .i_tx_data  (tx_data[g]),
      .i_tx_valid (tx_valid[g]),
      .o_tx_ready (tx_ready[g]),
      .o_overrun  (overrun[g]),
      .o_underrun (underrun[g])
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
      ,
      .o_frame_err(frame_err[g])
`endif
    );
  end

  always @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (overrun[k])  ovr_cnt[k] <= ovr_cnt[k] + 1;
      if (underrun[k]) und_cnt[k] <= und_cnt[k] + 1;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
      if (frame_err[k]) ferr_cnt[k] <= ferr_cnt[k] + 1;
`endif
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push_tx(input int m, input logic [7:0] d);
    @(negedge clk);
    tx_data[m]  = d;
    tx_valid[m] = 1'b1;
    @(negedge clk);
    tx_valid[m] = 1'b0;
  endtask

  task automatic ack(input int m);
    @(negedge clk);
    rx_ready[m] = 1'b1;
    @(negedge clk);
    rx_ready[m] = 1'b0;
  endtask

  task automatic cs_lo(input int m);
    @(negedge clk);
    cs_n[m] = 1'b0;
    #HALF;
  endtask

  task automatic cs_hi(input int m);
    #HALF;
    cs_n[m] = 1'b1;
    #(2 * HALF);
  endtask

  // Master side: drives bits hi..lo of b, returns MISO captured on the master's sample edge.
  task automatic xfer(input int m, input logic [7:0] b, input int hi, input int lo,
                      output logic [7:0] r);
    logic pol, pha;
    pol = (m >= 2);
    pha = (m % 2 == 1);
    r   = '0;
    if (!pha) mosi[m] = b[hi];
    for (int i = hi; i >= lo; i--) begin
      if (!pha) r[i] = miso[m];
      sck[m] = ~pol;
      if (pha) mosi[m] = b[i];
      #HALF;
      if (pha) r[i] = miso[m];
      sck[m] = pol;
      if (!pha && i > lo) mosi[m] = b[i-1];
      #HALF;
    end
  endtask

  initial begin
    logic [7:0] ra, rb, rc;
    int u0, o0;
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    int f0;
`endif
    for (int k = 0; k < 4; k++) tx_data[k] = '0;

    repeat (4) @(negedge clk);
    chk("reset_rx_valid", 32'(rx_valid[0]), 32'd0);
    chk("reset_tx_ready", 32'(tx_ready[0]), 32'd1);
    chk("reset_miso_oe",  32'(miso_oe[0]),  32'd0);
    chk("reset_miso",     32'(miso[0]),     32'd0);
    chk("reset_rx_data",  32'(rx_data[0]),  32'h00);
    rst = 1'b0;
    repeat (5) @(negedge clk);

    // mode 0: receive 0xA5 while returning 0x3C
    push_tx(0, 8'h3C);
    chk("t1_tx_ready_full", 32'(tx_ready[0]), 32'd0);
    u0 = und_cnt[0];
    cs_lo(0);
    chk("t1_miso_oe", 32'(miso_oe[0]), 32'd1);
    xfer(0, 8'hA5, 7, 0, ra);
    cs_hi(0);
    chk("t1_miso_word", 32'(ra), 32'h3C);
    chk("t1_rx_valid",  32'(rx_valid[0]), 32'd1);
    chk("t1_rx_data",   32'(rx_data[0]), 32'hA5);
    chk("t1_underrun_end_load", 32'(und_cnt[0] - u0), 32'd1);
    chk("t1_tx_ready_empty", 32'(tx_ready[0]), 32'd1);
    ack(0);
    chk("t1_rx_valid_cleared", 32'(rx_valid[0]), 32'd0);

    // back-to-back words, consumer stalled
    o0 = ovr_cnt[0];
    u0 = und_cnt[0];
    cs_lo(0);
    xfer(0, 8'h11, 7, 0, ra);
    xfer(0, 8'h22, 7, 0, rb);
    cs_hi(0);
    chk("t2_rx_data_first_kept", 32'(rx_data[0]), 32'h11);
    chk("t2_rx_valid", 32'(rx_valid[0]), 32'd1);
    chk("t2_overrun_once", 32'(ovr_cnt[0] - o0), 32'd1);
    chk("t2_miso_ones", 32'(ra), 32'hFF);
    chk("t2_underruns", 32'(und_cnt[0] - u0), 32'd3);
    ack(0);

    // empty holding at frame start, refill mid-word
    rx_ready[0] = 1'b1;
    u0 = und_cnt[0];
    cs_lo(0);
    xfer(0, 8'h0F, 7, 4, ra);
    push_tx(0, 8'h5A);
    xfer(0, 8'h0F, 3, 0, rb);
    xfer(0, 8'hF0, 7, 0, rc);
    cs_hi(0);
    chk("t3_miso_underrun_word", 32'(ra | rb), 32'hFF);
    chk("t3_miso_refill_word",   32'(rc), 32'h5A);
    chk("t3_rx_data", 32'(rx_data[0]), 32'hF0);
    chk("t3_rx_valid_consumed", 32'(rx_valid[0]), 32'd0);
    chk("t3_underruns", 32'(und_cnt[0] - u0), 32'd2);
    rx_ready[0] = 1'b0;

    // the other three SPI modes
    push_tx(3, 8'h96);
    u0 = und_cnt[3];
    cs_lo(3);
    xfer(3, 8'hC3, 7, 0, ra);
    cs_hi(3);
    chk("t4_m11_rx_data",  32'(rx_data[3]), 32'hC3);
    chk("t4_m11_rx_valid", 32'(rx_valid[3]), 32'd1);
    chk("t4_m11_miso",     32'(ra), 32'h96);
    chk("t4_m11_no_underrun", 32'(und_cnt[3] - u0), 32'd0);
    push_tx(1, 8'h69);
    cs_lo(1);
    xfer(1, 8'h3C, 7, 0, ra);
    cs_hi(1);
    chk("t4_m01_rx_data", 32'(rx_data[1]), 32'h3C);
    chk("t4_m01_miso",    32'(ra), 32'h69);
    push_tx(2, 8'hE1);
    cs_lo(2);
    xfer(2, 8'h1E, 7, 0, ra);
    cs_hi(2);
    chk("t4_m10_rx_data", 32'(rx_data[2]), 32'h1E);
    chk("t4_m10_miso",    32'(ra), 32'hE1);

    // frame aborted after 5 bits
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    f0 = ferr_cnt[0];
`endif
    cs_lo(0);
    xfer(0, 8'hB0, 7, 3, ra);
    cs_hi(0);
    chk("t5_no_rx_valid", 32'(rx_valid[0]), 32'd0);
    chk("t5_miso_oe_off", 32'(miso_oe[0]), 32'd0);
    chk("t5_miso_low",    32'(miso[0]), 32'd0);
`ifdef SPI_SLAVE_RX_FRAME_ERR_EN
    chk("t5_frame_err", 32'(ferr_cnt[0] - f0), 32'd1);
`endif
    cs_lo(0);
    xfer(0, 8'h81, 7, 0, ra);
    cs_hi(0);
    chk("t5_next_word_aligned", 32'(rx_data[0]), 32'h81);
    ack(0);

    // reset mid-word with CS_N still low
    cs_lo(0);
    xfer(0, 8'hFF, 7, 5, ra);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("t6_rx_data_reset", 32'(rx_data[0]), 32'h00);
    xfer(0, 8'hC7, 7, 0, ra);
    chk("t6_stays_idle", 32'(miso_oe[0]), 32'd0);
    cs_hi(0);
    chk("t6_no_capture", 32'(rx_valid[0]), 32'd0);
    cs_lo(0);
    xfer(0, 8'h7E, 7, 0, ra);
    cs_hi(0);
    chk("t6_new_frame_data",  32'(rx_data[0]), 32'h7E);
    chk("t6_new_frame_valid", 32'(rx_valid[0]), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
